// File: rtl/risc_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : risc_multicycle_ctrl                                         |
// | Description : Multi-cycle control sequencer for the KGP-RISC core. Steps   |
// |               each instruction through FETCH/DECODE/EXEC/MEM/WB. Data      |
// |               memory waits are bounded by MEM_TIMEOUT.                     |
// |               Optional macro ILLEGAL_TRAP_EN: invalid opcodes trap to HALT |
// |               (left only by reset) instead of retiring as a NOP.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module risc_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       imem_ack_i,
  input  logic       dmem_ack_i,
  input  logic [3:0] opcode_i,
  input  logic [3:0] fcode_i,
  input  logic       br_cond_i,
  output logic       imem_req_o,
  output logic       ir_write_o,
  output logic       alu_src_imm_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       reg_write_o,
  output logic       pc_write_o,
  output logic       pc_sel_target_o,
  output logic       retire_o,
  output logic       mem_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_IMM  = 4'h1;
  localparam logic [3:0] OP_LDST = 4'h2;
  localparam logic [3:0] OP_BR   = 4'h4;

  // Counter value seen on the last permitted MEM cycle.
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    fsel_q, fsel_d;   // only fCode[1:0] select load/store
  logic [TW-1:0] cnt_q, cnt_d;
  logic          w_retire;
  logic          w_is_store;

  // Upper fCode bits select ALU functions in the datapath, not sequencing.
  logic unused_fcode_hi;
  assign unused_fcode_hi = ^fcode_i[3:2];

  assign w_is_store = (fsel_q == 2'b01);

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal-instruction flag; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
    end else if ((state_q == S_DECODE) && (opcode_i > OP_BR)) begin
      illegal_q <= 1'b1;
    end
  end
`endif

  // State, latched instruction fields and MEM wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      fsel_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fsel_q  <= fsel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control outputs; every retire also updates the PC.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    fsel_d          = fsel_q;
    cnt_d           = cnt_q;
    w_retire        = 1'b0;
    imem_req_o      = 1'b0;
    ir_write_o      = 1'b0;
    alu_src_imm_o   = 1'b0;
    dmem_req_o      = 1'b0;
    dmem_we_o       = 1'b0;
    reg_write_o     = 1'b0;
    pc_write_o      = 1'b0;
    pc_sel_target_o = 1'b0;
    retire_o        = 1'b0;
    mem_err_o       = 1'b0;
    busy_o          = (state_q != S_IDLE) && (state_q != S_HALT);

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d   = opcode_i;
        fsel_d = fcode_i[1:0];
        if (opcode_i <= OP_BR) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          // Retires through WB as a NOP; WB suppresses reg_write for it.
          state_d = S_WB;
`endif
        end
      end
      S_EXEC: begin
        alu_src_imm_o = (op_q == OP_IMM) || (op_q == OP_LDST);
        case (op_q)
          OP_R, OP_IMM: state_d = S_WB;
          OP_LDST: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          default: begin
            // Branches resolve and retire here.
            w_retire        = 1'b1;
            pc_sel_target_o = (op_q == OP_BR) ? 1'b1 : br_cond_i;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = w_is_store;
        if (dmem_ack_i) begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (w_is_store) w_retire = 1'b1;
          else            state_d  = S_WB;
        end else if (cnt_q == TIMEOUT_LAST) begin
          mem_err_o = 1'b1;
          w_retire  = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WB: begin
        reg_write_o = (op_q <= OP_LDST);
        w_retire    = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_retire) begin
      pc_write_o = 1'b1;
      retire_o   = 1'b1;
      state_d    = run_i ? S_FETCH : S_IDLE;
    end

`ifdef ILLEGAL_TRAP_EN
    if (illegal_q) state_d = S_HALT;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_risc_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_risc_multicycle_ctrl                                      |
// | Description : Directed self-checking bench for risc_multicycle_ctrl.       |
// |               Stimulus byte: {run, imem_ack, dmem_ack, br_cond, opcode}.   |
// |               Output vector: {imem_req, ir_write, alu_src_imm, dmem_req,   |
// |               dmem_we, reg_write, pc_write, pc_sel_target, retire,         |
// |               mem_err, busy}.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_risc_multicycle_ctrl;

  localparam logic [10:0] ZERO   = 11'h000;
  localparam logic [10:0] O_IMEM = 11'h400;
  localparam logic [10:0] O_IRW  = 11'h200;
  localparam logic [10:0] O_ALUI = 11'h100;
  localparam logic [10:0] O_DREQ = 11'h080;
  localparam logic [10:0] O_DWE  = 11'h040;
  localparam logic [10:0] O_RW   = 11'h020;
  localparam logic [10:0] O_PCW  = 11'h010;
  localparam logic [10:0] O_PCT  = 11'h008;
  localparam logic [10:0] O_RET  = 11'h004;
  localparam logic [10:0] O_ERR  = 11'h002;
  localparam logic [10:0] O_BSY  = 11'h001;

  localparam logic [10:0] FA   = O_IMEM | O_IRW | O_BSY;
  localparam logic [10:0] FW   = O_IMEM | O_BSY;
  localparam logic [10:0] BSY  = O_BSY;
  localparam logic [10:0] EXI  = O_ALUI | O_BSY;
  localparam logic [10:0] WBW  = O_RW | O_PCW | O_RET | O_BSY;
  localparam logic [10:0] LDM  = O_DREQ | O_BSY;
  localparam logic [10:0] STM  = O_DREQ | O_DWE | O_BSY;
  localparam logic [10:0] BRT  = O_PCW | O_PCT | O_RET | O_BSY;
  localparam logic [10:0] BRN  = O_PCW | O_RET | O_BSY;

  logic       clk;
  logic       rst_n;
  logic       run, imem_ack, dmem_ack, br_cond;
  logic [3:0] opcode, fcode;
  logic       imem_req, ir_write, alu_src_imm, dmem_req, dmem_we, reg_write;
  logic       pc_write, pc_sel_target, retire, mem_err, busy;
  logic [10:0] outs;

  int checks = 0;
  int passes = 0;

  assign outs = {imem_req, ir_write, alu_src_imm, dmem_req, dmem_we, reg_write,
                 pc_write, pc_sel_target, retire, mem_err, busy};

  risc_multicycle_ctrl #(
    .MEM_TIMEOUT(4),
    .TW(8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .run_i          (run),
    .imem_ack_i     (imem_ack),
    .dmem_ack_i     (dmem_ack),
    .opcode_i       (opcode),
    .fcode_i        (fcode),
    .br_cond_i      (br_cond),
    .imem_req_o     (imem_req),
    .ir_write_o     (ir_write),
    .alu_src_imm_o  (alu_src_imm),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .reg_write_o    (reg_write),
    .pc_write_o     (pc_write),
    .pc_sel_target_o(pc_sel_target),
    .retire_o       (retire),
    .mem_err_o      (mem_err),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    br_cond = 1'b0; opcode = 4'h0; fcode = 4'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (outs !== ZERO) $display("FAIL reset_hold: got %b expected %b", outs, ZERO);
    else passes++;
    run = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (outs !== ZERO) $display("FAIL reset_idle: got %b expected %b", outs, ZERO);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_r_type();
    logic [7:0]  stim [11];
    logic [10:0] expv [11];
    fcode = 4'h0;
    stim = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h40, 8'h40};
    expv = '{ZERO,  FA,    BSY,   BSY,   WBW,   FA,    BSY,   BSY,   WBW,   ZERO,  ZERO};
    for (int i = 0; i < 11; i++) begin
      {run, imem_ack, dmem_ack, br_cond, opcode} = stim[i];
      #1;
      checks++;
      if (outs !== expv[i]) $display("FAIL r_type step %0d: got %b expected %b", i, outs, expv[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_imm_fetch_wait();
    logic [7:0]  stim [7];
    logic [10:0] expv [7];
    fcode = 4'h0;
    // run dropped mid-instruction must not abort it
    stim = '{8'h81, 8'h81, 8'hC1, 8'h01, 8'h01, 8'h01, 8'h01};
    expv = '{ZERO,  FW,    FA,    BSY,   EXI,   WBW,   ZERO};
    for (int i = 0; i < 7; i++) begin
      {run, imem_ack, dmem_ack, br_cond, opcode} = stim[i];
      #1;
      checks++;
      if (outs !== expv[i]) $display("FAIL imm step %0d: got %b expected %b", i, outs, expv[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    logic [7:0]  stim [9];
    logic [10:0] expv [9];
    fcode = 4'h0;
    stim = '{8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hE2, 8'h42, 8'h42};
    expv = '{ZERO,  FA,    BSY,   EXI,   LDM,   LDM,   LDM,   WBW,   ZERO};
    for (int i = 0; i < 9; i++) begin
      {run, imem_ack, dmem_ack, br_cond, opcode} = stim[i];
      #1;
      checks++;
      if (outs !== expv[i]) $display("FAIL load step %0d: got %b expected %b", i, outs, expv[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_store_timeout();
    logic [7:0]  stim [9];
    logic [10:0] expv [9];
    fcode = 4'h1;
    // case 0: never acked -> abort on 4th MEM cycle; case 1: ack on that cycle wins
    for (int c = 0; c < 2; c++) begin
      stim = '{8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'h42, 8'h42};
      expv = '{ZERO,  FA,    BSY,   EXI,   STM,   STM,   STM,   STM | O_PCW | O_RET | O_ERR, ZERO};
      if (c == 1) begin
        stim[7] = 8'h62;
        expv[7] = STM | O_PCW | O_RET;
      end
      for (int i = 0; i < 9; i++) begin
        {run, imem_ack, dmem_ack, br_cond, opcode} = stim[i];
        #1;
        checks++;
        if (outs !== expv[i])
          $display("FAIL store_timeout case %0d step %0d: got %b expected %b", c, i, outs, expv[i]);
        else passes++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0]  ops [3];
    logic        brs [3];
    logic [10:0] exex [3];
    logic [10:0] expv [5];
    ops  = '{4'h3, 4'h3, 4'h4};
    brs  = '{1'b1, 1'b0, 1'b0};
    exex = '{BRT,  BRN,  BRT};
    fcode = 4'h0;
    for (int c = 0; c < 3; c++) begin
      expv = '{ZERO, FA, BSY, exex[c], ZERO};
      for (int i = 0; i < 5; i++) begin
        run = (i < 3); imem_ack = 1'b1; dmem_ack = 1'b0;
        br_cond = brs[c]; opcode = ops[c];
        #1;
        checks++;
        if (outs !== expv[i])
          $display("FAIL branch case %0d step %0d: got %b expected %b", c, i, outs, expv[i]);
        else passes++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  stim [13];
    logic [10:0] expv [13];
    fcode = 4'h0;
    stim = '{8'hC4, 8'hC4, 8'hC4, 8'hC4, 8'hC0, 8'hC0, 8'hC0, 8'hC0,
             8'hC1, 8'hC1, 8'hC1, 8'h41, 8'h41};
    expv = '{ZERO,  FA,    BSY,   BRT,   FA,    BSY,   BSY,   WBW,
             FA,    BSY,   EXI,   WBW,   ZERO};
    for (int i = 0; i < 13; i++) begin
      {run, imem_ack, dmem_ack, br_cond, opcode} = stim[i];
      #1;
      checks++;
      if (outs !== expv[i]) $display("FAIL back_to_back step %0d: got %b expected %b", i, outs, expv[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [7:0]  stim [8];
    logic [10:0] expv [8];
    fcode = 4'h0;
    stim = '{8'hC7, 8'hC7, 8'hC7, 8'hC7, 8'hC4, 8'hC4, 8'h44, 8'h44};
`ifdef ILLEGAL_TRAP_EN
    expv = '{ZERO,  FA,    BSY,   ZERO,  ZERO,  ZERO,  ZERO,  ZERO};
`else
    expv = '{ZERO,  FA,    BSY,   BRN,   FA,    BSY,   BRT,   ZERO};
`endif
    for (int i = 0; i < 8; i++) begin
      {run, imem_ack, dmem_ack, br_cond, opcode} = stim[i];
      #1;
      checks++;
      if (outs !== expv[i]) $display("FAIL illegal step %0d: got %b expected %b", i, outs, expv[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [7:0]  stim [5];
    logic [10:0] expv [5];
    rst_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fcode = 4'h0;
    stim = '{8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2};
    expv = '{ZERO,  FA,    BSY,   EXI,   LDM};
    for (int i = 0; i < 5; i++) begin
      {run, imem_ack, dmem_ack, br_cond, opcode} = stim[i];
      #1;
      checks++;
      if (outs !== expv[i]) $display("FAIL reset_mid_mem step %0d: got %b expected %b", i, outs, expv[i]);
      else passes++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (outs !== LDM) $display("FAIL mem_before_reset: got %b expected %b", outs, LDM);
    else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== ZERO) $display("FAIL async_drop: got %b expected %b", outs, ZERO);
    else passes++;
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (outs !== ZERO) $display("FAIL post_reset_idle: got %b expected %b", outs, ZERO);
    else passes++;
    run = 1'b1;
    opcode = 4'h0;
    @(negedge clk);
    #1;
    checks++;
    if (outs !== FA) $display("FAIL post_reset_fetch: got %b expected %b", outs, FA);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_imm_fetch_wait();
    test_load();
    test_store_timeout();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_multicycle_ctrl.md
Name: risc_multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the KGP-RISC core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Consumes opcode/fCode from the instruction decoder and drives IR/PC/register-file/ALU/data-memory enables.
- Handshakes with instruction and data memory; bounded wait on data memory.

Parameters:
- MEM_TIMEOUT, 15, max cycles MEM waits for dmem_ack before abort (1..255).
- TW, 8, width of internal timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- run  in  1  1 = keep executing; sampled at instruction boundaries
- imem_ack  in  1  instruction word valid this cycle
- dmem_ack  in  1  data memory access complete this cycle
- opcode  in  4  decoder opcode (0000 R, 0001 imm, 0010 ld/st, 0011 branch-reg, 0100 branch)
- fcode  in  4  decoder fCode; for opcode 0010, fcode[1:0]=00 load, 01 store
- br_cond  in  1  datapath branch condition for opcode 0011
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- alu_src_imm  out  1  ALU B operand = immediate
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- reg_write  out  1  register-file write enable
- pc_write  out  1  PC update enable
- pc_sel_target  out  1  0 = PC+4, 1 = branch/label target
- retire  out  1  one-cycle pulse per completed instruction
- mem_err  out  1  one-cycle pulse on data-memory timeout
- busy  out  1  state != IDLE and != HALT

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - 3-bit registered state; outputs combinational from state, latched op/fcode and acks.
- Reset (rst=0, async):
  - state=IDLE; latched op/fcode=0; timeout counter=0.
  - All outputs 0.
  - Reset mid-MEM drops dmem_req immediately; no retire.
- IDLE:
  - run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1 until imem_ack.
  - ack cycle: ir_write=1, next DECODE.
  - No timeout on fetch.
- DECODE (1 cycle):
  - Latch opcode/fcode.
  - Next EXEC for opcodes 0000-0100.
  - Other opcodes: see Optional Feature.
- EXEC (1 cycle):
  - alu_src_imm=1 for opcode 0001 and 0010.
  - 0000/0001 -> WB.
  - 0010 -> MEM; timeout counter cleared.
  - 0011/0100: retire cycle, next FETCH/IDLE.
    - pc_write=1.
    - pc_sel_target = 1 for 0100; = br_cond for 0011.
- MEM:
  - dmem_req=1; dmem_we=1 iff store.
  - Counter increments each cycle without ack.
  - Load ack -> WB.
  - Store ack: retire cycle (pc_write=1, sel 0).
  - Counter reaching MEM_TIMEOUT with no ack: abort.
    - mem_err=1, pc_write=1, retire=1 that cycle.
    - No reg_write.
  - Ack on the timeout cycle counts as success, not timeout.
- WB (1 cycle):
  - reg_write=1, pc_write=1, pc_sel_target=0.
  - Retire cycle.
- After any retire cycle:
  - run=1 -> FETCH.
  - run=0 -> IDLE.
  - Dropping run mid-instruction never aborts it.
- Latency with zero-wait acks (fetch ack on first FETCH cycle):
  - R/imm 4 cycles; load 5; store 4; branch 3.
- retire is asserted exactly when pc_write=1.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Invalid opcode (>=0101) in DECODE -> HALT; internal illegal flag set.
  - HALT holds all outputs 0, busy=0, no retire; exits only via reset.
- Undefined:
  - Invalid opcode treated as NOP.
  - DECODE -> WB with reg_write=0, pc_write=1, retire=1.
  - Total 3 cycles.

Test Plan:
- Reset, run=1, imem_ack tied 1, opcode 0000 -> ir_write cycle 1, reg_write+pc_write+retire cycle 3 after FETCH, repeating every 4 cycles.
- Load (0010, fcode 00), dmem_ack after 3 MEM cycles -> dmem_req high 3 cycles, dmem_we=0, then WB reg_write=1, one retire.
- Store (fcode 01), dmem_ack never, MEM_TIMEOUT=4 -> dmem_req+dmem_we high, mem_err+retire pulse on 4th MEM cycle, reg_write never 1.
- Opcode 0011: br_cond=1 -> pc_sel_target=1 in EXEC; br_cond=0 -> 0; opcode 0100 -> always 1; each retires in 3 cycles.
- Opcode 0111: with ILLEGAL_TRAP_EN -> HALT, busy=0, no further imem_req; without -> retire after DECODE, next FETCH.
- rst=0 asserted mid-MEM -> dmem_req falls same cycle, state IDLE; run=0 at retire -> IDLE, imem_req stays 0.
